// File: rtl/regread_port_arbiter_if.sv
// Shared register-file read port bundle between the requesters/regfile side
// (master) and the read-port arbiter (slave).
interface regread_port_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned IDW  = 2;

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0]         gnt;
  logic [AW-1:0]           rf_sel;
  logic [WIDTH-1:0]        rf_data;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [WIDTH-1:0]        rsp_data;

  modport master (
    output req, addr, rf_data,
    input  gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, addr, rf_data,
    output gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/regread_port_arbiter.sv
// Two-stage arbiter for one shared 32-entry register-file read port.
// Stage A picks a requester and drives the read mux select; stage B captures
// the mux output one cycle later. Fixed 2-cycle latency, one grant per cycle.
// Build option: define REGRD_ROUNDROBIN_EN for round-robin arbitration;
// otherwise fixed priority (index 0 highest) with no pointer state.
module regread_port_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREQ  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regread_port_arbiter_if.slave  bus
);

  localparam int unsigned AW  = 5;
  localparam int unsigned IDW = 2;

  // Stage A state
  logic [NREQ-1:0]  gnt_q;
  logic [AW-1:0]    rf_sel_q;
  logic [IDW-1:0]   id_a_q;
  logic             val_a_q;

  // Stage B state
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

`ifdef REGRD_ROUNDROBIN_EN
  logic [IDW-1:0]   ptr_q;
`endif

  // Arbitration result
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win_onehot;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             win_found;

  // A requester granted last cycle is masked so its req drop is absorbed.
  assign elig = bus.req & ~gnt_q;

  // Winner search: fixed order 0..3, or rotated starting at ptr.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef REGRD_ROUNDROBIN_EN
      cand = ptr_q + IDW'(k);
`else
      cand = IDW'(k);
`endif
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = win_found;
  end

  // Stage A: register grant pulse, read select and owner id.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q    <= '0;
      rf_sel_q <= '0;
      id_a_q   <= '0;
      val_a_q  <= 1'b0;
    end else begin
      gnt_q   <= win_onehot;
      val_a_q <= win_found;
      if (win_found) begin
        rf_sel_q <= bus.addr[win_idx];
        id_a_q   <= win_idx;
      end
    end
  end

`ifdef REGRD_ROUNDROBIN_EN
  // Priority pointer moves just past the last winner; holds when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (win_found) begin
      ptr_q <= win_idx + IDW'(1);
    end
  end
`endif

  // Stage B: capture mux output for the transaction stage A launched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= val_a_q;
      if (val_a_q) begin
        rsp_id_q   <= id_a_q;
        rsp_data_q <= bus.rf_data;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rf_sel    = rf_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  // Grant is never more than one-hot; a response always follows a grant.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q));
  a_rsp_after_gnt : assert property (@(posedge clk) disable iff (!reset_n)
    rsp_valid_q |-> $past(val_a_q));

endmodule

// File: doc/regread_port_arbiter.md
REGREAD_PORT_ARBITER -- requirements
Module: regread_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data width of the shared register-file read port.
REQ-002 Parameter NREQ, fixed at 4, number of requesters; other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  per-requester read request, level; held high until gnt.
REQ-006 addr  input  4x5  per-requester register index; held stable while req is high.
REQ-007 gnt  output  4  one-hot registered grant pulse, one cycle long.
REQ-008 rf_sel  output  5  registered select driven to the 32x64 read mux.
REQ-009 rf_data  input  WIDTH  combinational mux output for the current rf_sel.
REQ-010 rsp_valid  output  1  registered response strobe.
REQ-011 rsp_id  output  2  requester index owning the current response.
REQ-012 rsp_data  output  WIDTH  registered read data.

Function
REQ-013 Stage A (edge ending cycle N): among eligible requests, pick a winner w; load rf_sel<=addr[w], id_a<=w, val_a<=1, gnt<=onehot(w).
REQ-014 When no request is eligible, val_a<=0, gnt<=0, and rf_sel holds its previous value.
REQ-015 Stage B (edge ending cycle N+1): when val_a=1, rsp_data<=rf_data, rsp_id<=id_a, rsp_valid<=1; otherwise rsp_valid<=0 and rsp_data/rsp_id hold.
REQ-016 Latency: request sampled in cycle N -> gnt high in N+1 -> rsp_valid high in N+2; fixed, no stalls.
REQ-017 Throughput: one grant per cycle; stages A and B operate concurrently.
REQ-018 Eligibility: req[i]=1 and gnt[i]=0 in the current cycle; a requester granted last cycle is masked for one cycle to absorb its req drop.
REQ-019 A requester that keeps req high after gnt is treated as a new request, granted again no earlier than 2 cycles later.
REQ-020 Round-robin mode: pointer ptr (2 bits) gives the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-021 After a grant to w, ptr<=(w+1) mod 4; w=3 wraps ptr to 0; ptr holds when no grant occurs.
REQ-022 Address 31 is passed through like any other index; no zero-register special casing.
REQ-023 At most one gnt bit is high in any cycle; rsp_valid is never high for a cycle with no matching prior grant.

Reset
REQ-024 reset_n low asynchronously clears gnt=0, val_a=0, rsp_valid=0, rf_sel=0, id_a=0, rsp_id=0, rsp_data=0, ptr=0.
REQ-025 Reset asserted mid-operation discards the in-flight stage A and B transactions; no response is issued for them after release.
REQ-026 First grant is possible on the first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro REGRD_ROUNDROBIN_EN: when defined, arbitration is round-robin per REQ-020/021.
REQ-028 When REGRD_ROUNDROBIN_EN is undefined, arbitration is fixed priority (index 0 highest, 3 lowest), ptr is not implemented, and all other behaviour is unchanged.

Verification
REQ-029 Single request: req=0001, addr[0]=7, rf_data=mux(7)=0xDEAD_BEEF_0000_0007 -> gnt=0001 at N+1, rf_sel=7, rsp_valid=1 with rsp_id=0 and that data at N+2.
REQ-030 All four requesters held high continuously, RR build, ptr=0 -> grant order 0,1,2,3,0 with one grant per cycle; ptr wraps 3->0.
REQ-031 All four held high, fixed-priority build -> alternating grants 0,1,0,1 (mask rule); 2 and 3 are never granted while 0 and 1 persist.
REQ-032 Back-to-back grants to ids 2 then 3 with addrs 31 and 5 -> rsp_id 2 with mux(31) at cycle k, rsp_id 3 with mux(5) at k+1.
REQ-033 reset_n pulsed low in the cycle after a gnt -> rsp_valid stays 0 and all outputs read zero; next request after release completes with 2-cycle latency.
REQ-034 req deasserted with no grants pending for 3 cycles -> gnt=0, rsp_valid=0, rf_sel and ptr unchanged.
